pc_seq_monitor: RTL and testbench
=================================

// Module: pc_seq_monitor
// PURPOSE
//  Receive-side checker for the pc counter: samples a W-bit counter's q/qn outputs once per
//  counter step, locks onto the count, and flags complement and sequence errors.
//  Sits beside pc in bring-up/self-test; pc drives, this block consumes and reports.
// PARAMETERS
//  W            2   counter width (bits of cnt_q / cnt_qn)
//  ERR_CNT_W    8   width of err_cnt and wrap_cnt (both saturating)
//  STOP_ON_ERR  0   1: first sequence error halts tracking; 0: resync and continue
// PORTS
//  clk        in   1          single clock; all state updates on posedge
//  rst        in   1          synchronous, active-high reset
//  cnt_vld    in   1          sample strobe: one pulse per counter step
//  cnt_q      in   W          counter true outputs
//  cnt_qn     in   W          counter complement outputs
//  clr        in   1          soft clear of state and statistics
//  locked     out  1          1 while in TRACK
//  exp_q      out  W          next expected count
//  err_compl  out  1          1-cycle pulse: cnt_qn != ~cnt_q on a sample
//  err_seq    out  1          1-cycle pulse: cnt_q != exp_q on a TRACK sample
//  err_sticky out  1          set by any error; cleared only by rst/clr
//  err_cnt    out  ERR_CNT_W  erroneous samples seen (saturating)
//  wrap_cnt   out  ERR_CNT_W  clean wrap-arounds seen (saturating)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM = IDLE. Priority: rst > clr > cnt_vld.
//  - All outputs registered; sample at edge N is reflected after edge N (1-cycle latency).
//  - cnt_vld=0: no state change; err_compl and err_seq are 0.
//  - FSM IDLE: on vld with good complement: exp_q<=cnt_q+1, go TRACK.
//    On vld with bad complement: err_compl pulse, err_cnt+1, stay IDLE.
//  - FSM TRACK: on vld, complement and sequence checks are both run on cnt_q.
//    Clean sample: exp_q<=cnt_q+1 (mod 2^W). If cnt_q == all ones, wrap_cnt+1.
//    Sequence error: err_seq pulse. With STOP_ON_ERR=0, resync exp_q<=cnt_q+1 and stay in TRACK.
//    With STOP_ON_ERR=1, go to HALT.
//    Complement error alone: err_compl pulse; exp_q still advances from cnt_q.
//  - Both errors on one sample: both pulses; err_cnt increments by 1 (one per sample).
//  - FSM HALT: locked=0; cnt_vld ignored; exit only via clr or rst, to IDLE.
//  - clr: FSM=IDLE. Zeroes exp_q, err_sticky, err_cnt, wrap_cnt and the pulses.
//    A cnt_vld in the same cycle is dropped.
//  - err_cnt/wrap_cnt hold at 2^ERR_CNT_W-1; they do not wrap.
//  - W=1 is legal: the expected sequence is 0,1,0,1.
//  - Reset mid-TRACK: next cycle identical to post-reset state; any concurrent sample is lost.
// CONFIGURATION
//  PC_SEQ_MON_DOWN_EN defined: adds input cnt_dn (1 bit).
//    When cnt_dn=1, expected value is cnt_q-1 and a clean sample with cnt_q==0 counts a wrap.
//    cnt_dn is sampled with cnt_vld and may change between samples without error.
//  Not defined: port cnt_dn is absent; up-count checking only.
// TESTING
//  1 rst; vld q=0,1,2,3,0,1 with qn=~q -> locked=1 after 1st sample, no errs, wrap_cnt=1, exp_q=2
//  2 TRACK, exp_q=2, sample q=2 qn=2'b11 -> err_compl for 1 cycle, err_seq=0, err_cnt=1,
//    err_sticky=1, exp_q=3
//  3 STOP_ON_ERR=0: q=0,1,3,0 -> err_seq pulse on the q=3 sample, err_cnt=1, exp_q=0,
//    then the q=0 sample is clean
//  4 STOP_ON_ERR=1: q=0,2 -> HALT, locked=0; further vld leaves err_cnt=1;
//    clr -> IDLE, all outputs 0
//  5 ERR_CNT_W=2: five bad-complement samples -> err_cnt holds at 3;
//    q=1,qn=1 with exp_q=2 -> both pulses, err_cnt+1 only
//  6 rst=1 together with vld in TRACK -> all outputs 0 next cycle; with PC_SEQ_MON_DOWN_EN
//    and cnt_dn=1: q=1,0,3 -> clean, wrap_cnt=1

Source files
------------

// File: rtl/pc_seq_monitor.sv
// pc_seq_monitor: receive-side checker for the pc counter.
// Samples cnt_q/cnt_qn on each cnt_vld strobe and locks onto the count.
// Reports complement and sequence errors, and keeps saturating error and
// wrap statistics.
// Optional feature macro: PC_SEQ_MON_DOWN_EN adds the cnt_dn input for
// down-count checking. Without it, only up-counting is checked.
module pc_seq_monitor #(
   parameter int unsigned W           = 2,
   parameter int unsigned ERR_CNT_W   = 8,
   parameter bit          STOP_ON_ERR = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cnt_vld,
   input  logic [W-1:0]         cnt_q,
   input  logic [W-1:0]         cnt_qn,
`ifdef PC_SEQ_MON_DOWN_EN
   input  logic                 cnt_dn,
`endif
   input  logic                 clr,
   output logic                 locked,
   output logic [W-1:0]         exp_q,
   output logic                 err_compl,
   output logic                 err_seq,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [ERR_CNT_W-1:0] wrap_cnt
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_TRACK = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam logic [W-1:0]         CNT_ONE  = W'(1);
   localparam logic [W-1:0]         CNT_ZERO = '0;
   localparam logic [W-1:0]         CNT_ONES = '1;
   localparam logic [ERR_CNT_W-1:0] STAT_ONE = ERR_CNT_W'(1);
   localparam logic [ERR_CNT_W-1:0] STAT_MAX = '1;

   logic [1:0]           state_q, state_d;
   logic                 locked_q, locked_d;
   logic [W-1:0]         exp_cnt_q, exp_cnt_d;
   logic                 compl_q, compl_d;
   logic                 seq_q, seq_d;
   logic                 sticky_q, sticky_d;
   logic [ERR_CNT_W-1:0] errc_q, errc_d;
   logic [ERR_CNT_W-1:0] wrap_q, wrap_d;

   logic                 dn;
   logic                 compl_ok;
   logic                 seq_bad;
   logic                 wrap_hit;
   logic [W-1:0]         nxt_exp;

`ifdef PC_SEQ_MON_DOWN_EN
   assign dn = cnt_dn;
`else
   assign dn = 1'b0;
`endif

   // Per-sample checks: complement match, sequence match, and next prediction.
   always_comb begin
      compl_ok = (cnt_qn == ~cnt_q);
      seq_bad  = (cnt_q != exp_cnt_q);
      nxt_exp  = dn ? (cnt_q - CNT_ONE) : (cnt_q + CNT_ONE);
      wrap_hit = (cnt_q == (dn ? CNT_ZERO : CNT_ONES));
   end

   // FSM and statistics next-state. Error pulses default low every cycle.
   always_comb begin
      state_d   = state_q;
      exp_cnt_d = exp_cnt_q;
      compl_d   = 1'b0;
      seq_d     = 1'b0;
      sticky_d  = sticky_q;
      errc_d    = errc_q;
      wrap_d    = wrap_q;
      if (cnt_vld) begin
         case (state_q)
            ST_IDLE: begin
               if (compl_ok) begin
                  exp_cnt_d = nxt_exp;
                  state_d   = ST_TRACK;
               end else begin
                  compl_d  = 1'b1;
                  sticky_d = 1'b1;
                  errc_d   = (errc_q == STAT_MAX) ? errc_q : errc_q + STAT_ONE;
               end
            end
            ST_TRACK: begin
               compl_d = ~compl_ok;
               seq_d   = seq_bad;
               // A sequence error either halts or resyncs. A complement error
               // alone still advances the prediction from the sampled value.
               if (seq_bad && STOP_ON_ERR) begin
                  state_d = ST_HALT;
               end else begin
                  exp_cnt_d = nxt_exp;
               end
               if (!compl_ok || seq_bad) begin
                  sticky_d = 1'b1;
                  errc_d   = (errc_q == STAT_MAX) ? errc_q : errc_q + STAT_ONE;
               end else if (wrap_hit) begin
                  wrap_d = (wrap_q == STAT_MAX) ? wrap_q : wrap_q + STAT_ONE;
               end
            end
            ST_HALT: begin
               state_d = ST_HALT;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      locked_d = (state_d == ST_TRACK);
   end

   // State registers. Reset takes priority over clear, and clear over a sample.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_q   <= ST_IDLE;
         locked_q  <= 1'b0;
         exp_cnt_q <= '0;
         compl_q   <= 1'b0;
         seq_q     <= 1'b0;
         sticky_q  <= 1'b0;
         errc_q    <= '0;
         wrap_q    <= '0;
      end else begin
         state_q   <= state_d;
         locked_q  <= locked_d;
         exp_cnt_q <= exp_cnt_d;
         compl_q   <= compl_d;
         seq_q     <= seq_d;
         sticky_q  <= sticky_d;
         errc_q    <= errc_d;
         wrap_q    <= wrap_d;
      end
   end

   assign locked     = locked_q;
   assign exp_q      = exp_cnt_q;
   assign err_compl  = compl_q;
   assign err_seq    = seq_q;
   assign err_sticky = sticky_q;
   assign err_cnt    = errc_q;
   assign wrap_cnt   = wrap_q;

endmodule

// File: tb/tb_pc_seq_monitor.sv
// Testbench for pc_seq_monitor.
// Instantiates four configurations on shared stimulus:
//   default, STOP_ON_ERR=1, ERR_CNT_W=2 and W=1.
// Expected outputs are queued per driven cycle and compared after the edge.
module tb_pc_seq_monitor;

   typedef struct packed {
      logic       locked;
      logic [1:0] exp_q;
      logic       ec;
      logic       es;
      logic       st;
      logic [7:0] cnt;
      logic [7:0] wr;
   } exp_t;

   typedef struct packed {
      logic       rst;
      logic       clr;
      logic       vld;
      logic [1:0] q;
      logic [1:0] qn;
      logic       dn;
   } stim_t;

   logic       clk = 1'b0;
   logic       rst, clr, cnt_vld, cnt_dn;
   logic [1:0] cnt_q, cnt_qn;

   logic       d0_l, d0_ec, d0_es, d0_st;
   logic [1:0] d0_e;
   logic [7:0] d0_c, d0_w;
   logic       d1_l, d1_ec, d1_es, d1_st;
   logic [1:0] d1_e;
   logic [7:0] d1_c, d1_w;
   logic       d2_l, d2_ec, d2_es, d2_st;
   logic [1:0] d2_e;
   logic [1:0] d2_c, d2_w;
   logic       d3_l, d3_ec, d3_es, d3_st;
   logic [0:0] d3_e;
   logic [7:0] d3_c, d3_w;

   exp_t obs0, obs1, obs2, obs3;
   exp_t sb[$];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pc_seq_monitor #(.W(2), .ERR_CNT_W(8), .STOP_ON_ERR(1'b0)) dut0 (
      .clk(clk), .rst(rst), .cnt_vld(cnt_vld), .cnt_q(cnt_q), .cnt_qn(cnt_qn),
`ifdef PC_SEQ_MON_DOWN_EN
      .cnt_dn(cnt_dn),
`endif
      .clr(clr), .locked(d0_l), .exp_q(d0_e), .err_compl(d0_ec), .err_seq(d0_es),
      .err_sticky(d0_st), .err_cnt(d0_c), .wrap_cnt(d0_w));

   pc_seq_monitor #(.W(2), .ERR_CNT_W(8), .STOP_ON_ERR(1'b1)) dut1 (
      .clk(clk), .rst(rst), .cnt_vld(cnt_vld), .cnt_q(cnt_q), .cnt_qn(cnt_qn),
`ifdef PC_SEQ_MON_DOWN_EN
      .cnt_dn(cnt_dn),
`endif
      .clr(clr), .locked(d1_l), .exp_q(d1_e), .err_compl(d1_ec), .err_seq(d1_es),
      .err_sticky(d1_st), .err_cnt(d1_c), .wrap_cnt(d1_w));

   pc_seq_monitor #(.W(2), .ERR_CNT_W(2), .STOP_ON_ERR(1'b0)) dut2 (
      .clk(clk), .rst(rst), .cnt_vld(cnt_vld), .cnt_q(cnt_q), .cnt_qn(cnt_qn),
`ifdef PC_SEQ_MON_DOWN_EN
      .cnt_dn(cnt_dn),
`endif
      .clr(clr), .locked(d2_l), .exp_q(d2_e), .err_compl(d2_ec), .err_seq(d2_es),
      .err_sticky(d2_st), .err_cnt(d2_c), .wrap_cnt(d2_w));

   pc_seq_monitor #(.W(1), .ERR_CNT_W(8), .STOP_ON_ERR(1'b0)) dut3 (
      .clk(clk), .rst(rst), .cnt_vld(cnt_vld), .cnt_q(cnt_q[0:0]), .cnt_qn(cnt_qn[0:0]),
`ifdef PC_SEQ_MON_DOWN_EN
      .cnt_dn(cnt_dn),
`endif
      .clr(clr), .locked(d3_l), .exp_q(d3_e), .err_compl(d3_ec), .err_seq(d3_es),
      .err_sticky(d3_st), .err_cnt(d3_c), .wrap_cnt(d3_w));

   // Gather each instance's outputs into one comparable word.
   always_comb begin
      obs0 = {d0_l, d0_e, d0_ec, d0_es, d0_st, d0_c, d0_w};
      obs1 = {d1_l, d1_e, d1_ec, d1_es, d1_st, d1_c, d1_w};
      obs2 = {d2_l, d2_e, d2_ec, d2_es, d2_st, 6'd0, d2_c, 6'd0, d2_w};
      obs3 = {d3_l, 1'b0, d3_e, d3_ec, d3_es, d3_st, d3_c, d3_w};
   end

   function automatic exp_t mk(logic l, logic [1:0] e, logic ec, logic es, logic st,
                               logic [7:0] c, logic [7:0] w);
      exp_t r;
      r = {l, e, ec, es, st, c, w};
      return r;
   endfunction

   function automatic stim_t S(logic r, logic c, logic v, logic [1:0] q, logic [1:0] qn,
                               logic dn);
      stim_t s;
      s = {r, c, v, q, qn, dn};
      return s;
   endfunction

   task automatic apply(input stim_t s);
      rst     = s.rst;
      clr     = s.clr;
      cnt_vld = s.vld;
      cnt_q   = s.q;
      cnt_qn  = s.qn;
      cnt_dn  = s.dn;
   endtask

   task automatic test_reset();
      exp_t e;
      apply(S(1, 0, 0, 0, 0, 0));
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (obs0 !== e) begin
         n_fail++;
         $display("FAIL reset: got %h required %h", obs0, e);
      end
      n_tests++;
      if (obs2 !== e) begin
         n_fail++;
         $display("FAIL reset_w2cnt: got %h required %h", obs2, e);
      end
   endtask

   // Up count 0,1,2,3,0,1 then a bad complement and an idle cycle.
   task automatic test_track_and_compl();
      stim_t st[$];
      exp_t  ex[$];
      exp_t  e;
      st.push_back(S(0, 0, 1, 0, 3, 0)); ex.push_back(mk(1, 1, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 1, 2, 0)); ex.push_back(mk(1, 2, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 2, 1, 0)); ex.push_back(mk(1, 3, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 3, 0, 0)); ex.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      st.push_back(S(0, 0, 1, 0, 3, 0)); ex.push_back(mk(1, 1, 0, 0, 0, 0, 1));
      st.push_back(S(0, 0, 1, 1, 2, 0)); ex.push_back(mk(1, 2, 0, 0, 0, 0, 1));
      st.push_back(S(0, 0, 1, 2, 3, 0)); ex.push_back(mk(1, 3, 1, 0, 1, 1, 1));
      st.push_back(S(0, 0, 0, 1, 1, 0)); ex.push_back(mk(1, 3, 0, 0, 1, 1, 1));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_tests++;
         if (obs0 !== e) begin
            n_fail++;
            $display("FAIL track_compl[%0d]: got %h required %h", i, obs0, e);
         end
      end
   endtask

   task automatic test_seq_resync();
      stim_t st[$];
      exp_t  ex[$];
      exp_t  e;
      st.push_back(S(1, 0, 0, 0, 0, 0)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 0, 3, 0)); ex.push_back(mk(1, 1, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 1, 2, 0)); ex.push_back(mk(1, 2, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 3, 0, 0)); ex.push_back(mk(1, 0, 0, 1, 1, 1, 0));
      st.push_back(S(0, 0, 1, 0, 3, 0)); ex.push_back(mk(1, 1, 0, 0, 1, 1, 0));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_tests++;
         if (obs0 !== e) begin
            n_fail++;
            $display("FAIL seq_resync[%0d]: got %h required %h", i, obs0, e);
         end
      end
   endtask

   task automatic test_stop_on_err();
      stim_t st[$];
      exp_t  ex[$];
      exp_t  e;
      st.push_back(S(1, 0, 0, 0, 0, 0)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 0, 3, 0)); ex.push_back(mk(1, 1, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 2, 1, 0)); ex.push_back(mk(0, 1, 0, 1, 1, 1, 0));
      st.push_back(S(0, 0, 1, 1, 2, 0)); ex.push_back(mk(0, 1, 0, 0, 1, 1, 0));
      st.push_back(S(0, 0, 1, 3, 3, 0)); ex.push_back(mk(0, 1, 0, 0, 1, 1, 0));
      st.push_back(S(0, 1, 0, 0, 0, 0)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 3, 0, 0)); ex.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_tests++;
         if (obs1 !== e) begin
            n_fail++;
            $display("FAIL stop_on_err[%0d]: got %h required %h", i, obs1, e);
         end
      end
   endtask

   task automatic test_saturate_and_both();
      stim_t st[$];
      exp_t  ex[$];
      exp_t  e;
      st.push_back(S(1, 0, 0, 0, 0, 0)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 0, 0, 0)); ex.push_back(mk(0, 0, 1, 0, 1, 1, 0));
      st.push_back(S(0, 0, 1, 0, 0, 0)); ex.push_back(mk(0, 0, 1, 0, 1, 2, 0));
      st.push_back(S(0, 0, 1, 0, 0, 0)); ex.push_back(mk(0, 0, 1, 0, 1, 3, 0));
      st.push_back(S(0, 0, 1, 0, 0, 0)); ex.push_back(mk(0, 0, 1, 0, 1, 3, 0));
      st.push_back(S(0, 0, 1, 0, 0, 0)); ex.push_back(mk(0, 0, 1, 0, 1, 3, 0));
      st.push_back(S(0, 1, 0, 0, 0, 0)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 1, 2, 0)); ex.push_back(mk(1, 2, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 1, 1, 0)); ex.push_back(mk(1, 2, 1, 1, 1, 1, 0));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_tests++;
         if (obs2 !== e) begin
            n_fail++;
            $display("FAIL saturate_both[%0d]: got %h required %h", i, obs2, e);
         end
      end
   endtask

   task automatic test_rst_clr_with_vld();
      stim_t st[$];
      exp_t  ex[$];
      exp_t  e;
      st.push_back(S(1, 0, 0, 0, 0, 0)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 0, 3, 0)); ex.push_back(mk(1, 1, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 2, 2, 0)); ex.push_back(mk(1, 3, 1, 1, 1, 1, 0));
      st.push_back(S(1, 0, 1, 3, 0, 0)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 0, 3, 0, 0)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 0, 3, 0)); ex.push_back(mk(1, 1, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 1, 1, 0)); ex.push_back(mk(1, 2, 1, 0, 1, 1, 0));
      st.push_back(S(0, 1, 1, 2, 1, 0)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 2, 1, 0)); ex.push_back(mk(1, 3, 0, 0, 0, 0, 0));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_tests++;
         if (obs0 !== e) begin
            n_fail++;
            $display("FAIL rst_clr_vld[%0d]: got %h required %h", i, obs0, e);
         end
      end
   endtask

   task automatic test_w1();
      stim_t st[$];
      exp_t  ex[$];
      exp_t  e;
      st.push_back(S(1, 0, 0, 0, 0, 0)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 0, 1, 0)); ex.push_back(mk(1, 1, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 1, 0, 0)); ex.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      st.push_back(S(0, 0, 1, 0, 1, 0)); ex.push_back(mk(1, 1, 0, 0, 0, 0, 1));
      st.push_back(S(0, 0, 1, 1, 0, 0)); ex.push_back(mk(1, 0, 0, 0, 0, 0, 2));
      st.push_back(S(0, 0, 1, 1, 0, 0)); ex.push_back(mk(1, 0, 0, 1, 1, 1, 2));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_tests++;
         if (obs3 !== e) begin
            n_fail++;
            $display("FAIL w1[%0d]: got %h required %h", i, obs3, e);
         end
      end
   endtask

`ifdef PC_SEQ_MON_DOWN_EN
   task automatic test_down();
      stim_t st[$];
      exp_t  ex[$];
      exp_t  e;
      st.push_back(S(1, 0, 0, 0, 0, 1)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 1, 2, 1)); ex.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 0, 1, 0, 3, 1)); ex.push_back(mk(1, 3, 0, 0, 0, 0, 1));
      st.push_back(S(0, 0, 1, 3, 0, 1)); ex.push_back(mk(1, 2, 0, 0, 0, 0, 1));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_tests++;
         if (obs0 !== e) begin
            n_fail++;
            $display("FAIL down[%0d]: got %h required %h", i, obs0, e);
         end
      end
   endtask
`endif

   initial begin
      apply(S(1, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      test_reset();
      test_track_and_compl();
      test_seq_resync();
      test_stop_on_err();
      test_saturate_and_both();
      test_rst_clr_with_vld();
      test_w1();
`ifdef PC_SEQ_MON_DOWN_EN
      test_down();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
